// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS fetch-stage definitions: reset vector, bubble word, ROM geometry
// and the IF/ID payload type reused by later pipeline registers.
package instruction_fetch_pkg;

  localparam int          PC_W         = 32;
  localparam int          DEF_ROM_AW   = 6;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
// Template for the later pipeline registers.
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_valid,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc4_d,
  output if_id_t      q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr <= NOP_WORD;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (flush) begin
      q.instr <= NOP_WORD;
      q.pc4   <= '0;
      q.valid <= 1'b0;
    end else if (!stall) begin
      q.instr <= load_valid ? instr_d : NOP_WORD;
      q.pc4   <= pc4_d;
      q.valid <= load_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, combinational ROM addressing,
// IF/ID capture, sticky fetch-fault flag and fetched-instruction counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          ROM_AW   = DEF_ROM_AW,
  parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       if_id_instr_o,
  output logic [31:0]       if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic              fault_o,
  output logic [31:0]       fetch_cnt_o
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] fetched;
  logic        in_range;
  logic        misaligned;
  logic        loads_valid;
  if_id_t      if_id;

  assign in_range    = (pc[31:ROM_AW+2] == '0);
  assign rom_addr_o  = pc[ROM_AW+1:2];
  assign fetched     = in_range ? rom_data_i : NOP_WORD;
  assign pc4         = pc_plus4(pc);
  assign misaligned  = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign loads_valid = !flush_i && !stall_i && in_range;

  // Redirect wins over stall so a taken branch is never lost behind a hazard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (redirect_i)
      pc <= {redirect_pc_i[31:2], 2'b00};
    else if (!stall_i)
      pc <= pc4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_o     <= 1'b0;
      fetch_cnt_o <= '0;
    end else begin
      if (misaligned || (!stall_i && !in_range))
        fault_o <= 1'b1;
      if (loads_valid)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

  if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall_i),
    .flush     (flush_i),
    .load_valid(in_range),
    .instr_d   (fetched),
    .pc4_d     (pc4),
    .q         (if_id)
  );

  assign pc_o          = pc;
  assign if_id_instr_o = if_id.instr;
  assign if_id_pc4_o   = if_id.pc4;
  assign if_id_valid_o = if_id.valid;

endmodule
